stunir_result_sink: RTL and testbench
=====================================

Name: stunir_result_sink

Overview:
Downstream consumer of module_top's done/result completion interface. Detects each rising edge of done, captures the 32-bit result into a small FIFO, and drains captured results over a valid/ready stream toward the host/readback logic. Keeps a sticky overflow flag when results arrive faster than they are drained.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
RESULT_W, 32, result width; must equal the module_top result width.

Ports:
clk  in  1  system clock, 100 MHz nominal
rst_n  in  1  asynchronous active-low reset
done_i  in  1  completion level from module_top
result_i  in  RESULT_W  result from module_top; valid while done_i is high
m_valid  out  1  stream word available
m_ready  in  1  consumer accepts word
m_data  out  RESULT_W  head-of-FIFO result
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a capture was dropped because the FIFO was full
clr_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset (async, active-low) values: m_valid=0, m_data=0, level=0, overflow=0, pointers=0. Internal done_q resets to 1, so a done_i already high at reset release is not a capture.
- Edge detection: done_q <= done_i every cycle. capture = done_i & ~done_q. result_i is sampled in the capture cycle only. A level-high done_i held for many cycles yields exactly one entry.
- Pop: pop = m_valid & m_ready.
- Write: on capture, write the entry if level<DEPTH, or if level==DEPTH and pop is high in the same cycle (full plus simultaneous pop is accepted).
- Drop: on capture with level==DEPTH and no pop, drop the result and set overflow. The FIFO contents are untouched.
- Latency: capture in cycle N gives m_valid=1 and m_data=result in cycle N+1. There is no same-cycle bypass when the FIFO is empty.
- Output: first-word-fall-through. m_valid = (level!=0). m_data = head entry when m_valid, otherwise 0. m_data is stable while m_valid & ~m_ready.
- Level update:
  - capture-accepted & ~pop: +1
  - pop & ~capture-accepted: -1
  - both or neither: unchanged
- Pointers: log2(DEPTH)-bit pointers, wrap naturally modulo DEPTH.
- Overflow: set has priority over clr_overflow in the same cycle. Otherwise clr_overflow clears it next cycle.
- Reset mid-operation: all stored entries are discarded and outputs return to reset values immediately (asynchronous assert). Release is assumed synchronous to clk at the system level.
- m_ready while m_valid=0 is ignored.

Optional Feature:
Macro: STUNIR_RESULT_SINK_DROP_CNT_EN.
- Defined: adds output drop_count [15:0]. It increments once per dropped capture, saturates at 16'hFFFF, resets to 0, and is cleared together with overflow by clr_overflow. On a same-cycle drop plus clear, the count becomes 1.
- Undefined: the port and counter are absent. Overflow behaviour is unchanged.

Decomposition:
- Shared package stunir_fpga_pkg:
  - RESULT_W = 32
  - typedef result_t (logic [RESULT_W-1:0])
  - DROP_CNT_W = 16
- One sub-module is natural: stunir_sync_fifo (parameterised DEPTH/width, FWFT, wr_en/rd_en/level/full/empty).
- stunir_result_sink keeps the edge detect, drop/overflow logic and optional counter.

Test Plan:
- Reset with done_i=1 held through release, then 5 cycles: m_valid stays 0, level=0.
- One done pulse with result=32'd42, m_ready=1: m_valid=1 with m_data=42 exactly one cycle after the capture, popped that cycle, level returns to 0. Holding done_i high 10 cycles still yields one entry.
- m_ready=0, 8 done pulses carrying 1..8 (DEPTH=8): level=8, overflow=0. A 9th pulse with 9: overflow=1, level=8, drop_count=1 (macro on). Then m_ready=1: drains 1..8 in order, then m_valid=0.
- FIFO full (1..8) and m_ready=1 in the same cycle as a capture of 100: level stays 8, overflow=0, and 100 emerges after 2..8.
- overflow=1, clr_overflow pulsed in the same cycle as another dropped capture: overflow remains 1. A later lone clr_overflow: overflow=0, drop_count=0.
- rst_n asserted mid-stream with level=5: level, m_valid and m_data go to 0 immediately. After release, one done pulse with 7: only 7 appears.

Source files
------------

// File: rtl/stunir_fpga_pkg.sv
// Shared types and widths for the stunir FPGA result path.
package stunir_fpga_pkg;

  localparam int unsigned RESULT_W   = 32;
  localparam int unsigned DROP_CNT_W = 16;

  typedef logic [RESULT_W-1:0] result_t;

endpackage

// File: rtl/stunir_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. It has an occupancy count.
// A write to a full FIFO is accepted only when a read happens in the same cycle.
module stunir_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    cnt;
  logic             do_wr;
  logic             do_rd;

  assign empty = (cnt == '0);
  assign full  = (cnt == LW'(DEPTH));
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Output is gated to zero when empty, so stale memory never shows on the port.
  assign rd_data = empty ? '0 : mem[rd_ptr];
  assign level   = cnt;

endmodule

// File: rtl/stunir_result_sink.sv
// Captures module_top results on each rising edge of done and queues them to a valid/ready stream.
// Defining STUNIR_RESULT_SINK_DROP_CNT_EN adds a saturating drop_count output.
module stunir_result_sink
  import stunir_fpga_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned RESULT_W = stunir_fpga_pkg::RESULT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    done_i,
  input  logic [RESULT_W-1:0]     result_i,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [RESULT_W-1:0]     m_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  input  logic                    clr_overflow
`ifdef STUNIR_RESULT_SINK_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]   drop_count
`endif
);

  logic done_q;
  logic capture;
  logic pop;
  logic fifo_full;
  logic fifo_empty;
  logic wr_en;
  logic drop;

  // done_q resets high so a done already asserted at reset release is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b1;
    else        done_q <= done_i;
  end

  assign capture = done_i & ~done_q;
  assign pop     = m_valid & m_ready;
  assign wr_en   = capture & (~fifo_full | pop);
  assign drop    = capture & fifo_full & ~pop;
  assign m_valid = ~fifo_empty;

  stunir_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RESULT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (result_i),
    .rd_en   (pop),
    .rd_data (m_data),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

`ifdef STUNIR_RESULT_SINK_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (drop) begin
      if (clr_overflow)          drop_count <= DROP_CNT_W'(1);
      else if (drop_count != '1) drop_count <= drop_count + DROP_CNT_W'(1);
    end else if (clr_overflow) begin
      drop_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_stunir_result_sink.sv
// Scoreboard bench for stunir_result_sink: directed done pulses, with a monitor that checks popped stream words.
module tb_stunir_result_sink;
  import stunir_fpga_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic                   clk;
  logic                   rst_n;
  logic                   done_i;
  result_t                result_i;
  logic                   m_valid;
  logic                   m_ready;
  result_t                m_data;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;
  logic                   clr_overflow;
`ifdef STUNIR_RESULT_SINK_DROP_CNT_EN
  logic [DROP_CNT_W-1:0]  drop_count;
`endif

  int checks = 0;
  int errors = 0;
  result_t exp_q [$];

  stunir_result_sink #(
    .DEPTH    (DEPTH),
    .RESULT_W (RESULT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .done_i       (done_i),
    .result_i     (result_i),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .level        (level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef STUNIR_RESULT_SINK_DROP_CNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input result_t v, input bit expect_accept);
    done_i   = 1'b1;
    result_i = v;
    if (expect_accept) exp_q.push_back(v);
    tick();
    done_i   = 1'b0;
    result_i = '0;
    tick();
  endtask

  task automatic drain(input int unsigned max_cycles);
    m_ready = 1'b1;
    for (int unsigned i = 0; i < max_cycles && m_valid; i++) tick();
    chk("drain_m_valid", {31'd0, m_valid}, 32'd0);
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_sb_empty", exp_q.size(), 32'd0);
  endtask

  // Monitor: every accepted stream word must match the next expected result.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_unexpected: got 0x%0h expected no word at %0t", m_data, $time);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        if (m_data !== e) begin
          errors++;
          $display("FAIL stream_data: got 0x%0h expected 0x%0h at %0t", m_data, e, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    done_i       = 1'b1;
    result_i     = 32'hDEAD_BEEF;
    m_ready      = 1'b0;
    clr_overflow = 1'b0;

    // Reset state, with done held high through the release.
    #12;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("held_done_m_valid", {31'd0, m_valid}, 32'd0);
      chk("held_done_level", 32'(level), 32'd0);
    end
    done_i   = 1'b0;
    result_i = '0;
    tick();

    // Single pulse: one-cycle latency, no bypass.
    m_ready  = 1'b1;
    done_i   = 1'b1;
    result_i = 32'd42;
    exp_q.push_back(32'd42);
    chk("no_bypass_m_valid", {31'd0, m_valid}, 32'd0);
    tick();
    chk("lat_m_valid", {31'd0, m_valid}, 32'd1);
    chk("lat_m_data", m_data, 32'd42);
    done_i   = 1'b0;
    result_i = '0;
    tick();
    chk("pop_level", 32'(level), 32'd0);
    chk("pop_m_valid", {31'd0, m_valid}, 32'd0);

    // done held for 10 cycles gives exactly one entry, sampled on the edge cycle.
    done_i   = 1'b1;
    result_i = 32'd43;
    exp_q.push_back(32'd43);
    tick();
    result_i = 32'd44;
    for (int i = 0; i < 9; i++) tick();
    done_i   = 1'b0;
    result_i = '0;
    tick();
    tick();
    chk("hold_level", 32'(level), 32'd0);
    chk("hold_sb_empty", exp_q.size(), 32'd0);

    // Fill to DEPTH with no consumer, then overflow.
    m_ready = 1'b0;
    for (int unsigned v = 1; v <= 8; v++) pulse(v, 1'b1);
    chk("full_level", 32'(level), 32'd8);
    chk("full_overflow", {31'd0, overflow}, 32'd0);
    pulse(32'd9, 1'b0);
    chk("drop_overflow", {31'd0, overflow}, 32'd1);
    chk("drop_level", 32'(level), 32'd8);
    chk("drop_m_data_head", m_data, 32'd1);
`ifdef STUNIR_RESULT_SINK_DROP_CNT_EN
    chk("drop_count_1", 32'(drop_count), 32'd1);
`endif

    // Drop and clear in the same cycle: set wins.
    done_i       = 1'b1;
    result_i     = 32'd10;
    clr_overflow = 1'b1;
    tick();
    done_i       = 1'b0;
    result_i     = '0;
    clr_overflow = 1'b0;
    tick();
    chk("drop_clr_overflow", {31'd0, overflow}, 32'd1);
`ifdef STUNIR_RESULT_SINK_DROP_CNT_EN
    chk("drop_clr_count", 32'(drop_count), 32'd1);
`endif
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("clr_overflow", {31'd0, overflow}, 32'd0);
`ifdef STUNIR_RESULT_SINK_DROP_CNT_EN
    chk("clr_count", 32'(drop_count), 32'd0);
`endif
    drain(20);

    // Full FIFO with a pop in the same cycle as a capture: the capture is accepted.
    m_ready = 1'b0;
    for (int unsigned v = 1; v <= 8; v++) pulse(v, 1'b1);
    done_i   = 1'b1;
    result_i = 32'd100;
    m_ready  = 1'b1;
    exp_q.push_back(32'd100);
    tick();
    done_i   = 1'b0;
    result_i = '0;
    chk("full_pop_level", 32'(level), 32'd8);
    chk("full_pop_overflow", {31'd0, overflow}, 32'd0);
    drain(20);

    // Asynchronous reset mid-stream.
    m_ready = 1'b0;
    for (int unsigned v = 11; v <= 15; v++) pulse(v, 1'b1);
    chk("pre_rst_level", 32'(level), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_m_data", m_data, 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    m_ready = 1'b1;
    pulse(32'd7, 1'b1);
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
